// File: rtl/fetch_if.sv
// Fetch-side bundle: instruction memory request/response, redirect input and
// the decode-facing output handshake.
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding request to a 1-cycle-latency memory,
// a 2-entry {pc, inst} output buffer, and redirect-driven flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] hd_pc_q, hd_pc_d, hd_inst_q, hd_inst_d;
  logic [31:0] tl_pc_q, tl_pc_d, tl_inst_q, tl_inst_d;

  logic       pop, push, issue;
  logic [2:0] occ;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    hd_pc_d       = hd_pc_q;
    hd_inst_d     = hd_inst_q;
    tl_pc_d       = tl_pc_q;
    tl_inst_d     = tl_inst_q;

    pop   = (count_q != 2'd0) & bus.out_ready;
    push  = inflight_q & ~bus.redirect_valid;
    // Buffered plus in-flight entries, less the one leaving this cycle.
    occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = ~bus.redirect_valid & (occ < 3'd2);

    if (bus.redirect_valid) begin
      pc_d       = {bus.redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            hd_pc_d   = inflight_pc_q;
            hd_inst_d = bus.imem_inst;
          end else begin
            tl_pc_d   = inflight_pc_q;
            tl_inst_d = bus.imem_inst;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          hd_pc_d   = tl_pc_q;
          hd_inst_d = tl_inst_q;
          count_d   = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            hd_pc_d   = inflight_pc_q;
            hd_inst_d = bus.imem_inst;
          end else begin
            hd_pc_d   = tl_pc_q;
            hd_inst_d = tl_inst_q;
            tl_pc_d   = inflight_pc_q;
            tl_inst_d = bus.imem_inst;
          end
        end
        default: ;
      endcase
    end
  end

  // Data registers are reset too so the outputs read zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      count_q       <= 2'd0;
      hd_pc_q       <= 32'd0;
      hd_inst_q     <= 32'd0;
      tl_pc_q       <= 32'd0;
      tl_inst_q     <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      hd_pc_q       <= hd_pc_d;
      hd_inst_q     <= hd_inst_d;
      tl_pc_q       <= tl_pc_d;
      tl_inst_q     <= tl_inst_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_pc    = hd_pc_q;
  assign bus.out_inst  = hd_inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: registered memory model, queue-based reference of
// issued-but-undelivered addresses, and directed literal checkpoints.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000 + {2'b00, a[31:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory returns the word for last cycle's address.
  always @(posedge clk) bus.imem_inst <= memw(bus.imem_addr);

  typedef struct {
    logic [31:0] pc;
    int          ic;
  } ent_t;
  ent_t        q[$];
  logic [31:0] exp_addr;
  int          cyc;

  // Reference: every issued address becomes visible two cycles after issue and
  // leaves on handshake; a request may issue while fewer than two are owed.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_addr = RESET_PC;
      cyc = 0;
      check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_addr", bus.imem_addr, RESET_PC);
      check("rst_out_pc", bus.out_pc, 32'd0);
      check("rst_out_inst", bus.out_inst, 32'd0);
    end else begin
      logic ev;
      int   popn;
      ev = (q.size() > 0) && (q[0].ic <= cyc - 2);
      check("m_addr", bus.imem_addr, exp_addr);
      check("m_valid", {31'd0, bus.out_valid}, {31'd0, ev});
      if (ev) begin
        check("m_out_pc", bus.out_pc, q[0].pc);
        check("m_out_inst", bus.out_inst, memw(q[0].pc));
      end
      popn = (ev && bus.out_ready) ? 1 : 0;
      if (bus.redirect_valid) begin
        q.delete();
        exp_addr = {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (q.size() - popn < 2) begin
          q.push_back('{exp_addr, cyc});
          exp_addr = exp_addr + 32'd4;
        end
        if (popn == 1) void'(q.pop_front());
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startup_checks();
    @(negedge clk); check("s_addr0", bus.imem_addr, 32'h0);
    @(negedge clk); check("s_addr1", bus.imem_addr, 32'h4);
    @(negedge clk); check("s_addr2", bus.imem_addr, 32'h8);
    check("s_v0", {31'd0, bus.out_valid}, 32'd1);
    check("s_pc0", bus.out_pc, 32'h0);
    check("s_in0", bus.out_inst, 32'h1000);
    @(negedge clk);
    check("s_pc1", bus.out_pc, 32'h4);
    check("s_in1", bus.out_inst, 32'h1001);
    @(negedge clk);
    check("s_pc2", bus.out_pc, 32'h8);
    check("s_in2", bus.out_inst, 32'h1002);
  endtask

  initial begin
    logic [47:0] rdy_pat;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (3) step();
    rst = 1'b0;
    startup_checks();

    // Mid-stream stall
    step(); step();
    bus.out_ready = 1'b0;
    repeat (5) step();
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Fill the buffer, then redirect with a handshake in the same cycle
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rd_addr", bus.imem_addr, 32'h40);
    step(); step();
    @(negedge clk);
    check("rd_out_pc", bus.out_pc, 32'h40);
    check("rd_out_inst", bus.out_inst, 32'h1010);
    repeat (3) step();

    // Back-to-back redirects; last (unaligned) target wins
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_pc = 32'h43;
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("al_addr", bus.imem_addr, 32'h40);
    repeat (3) step();

    // Wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    step(); step();
    @(negedge clk);
    check("wr_pc0", bus.out_pc, 32'hFFFF_FFFC);
    check("wr_in0", bus.out_inst, 32'h4000_0FFF);
    step();
    @(negedge clk);
    check("wr_pc1", bus.out_pc, 32'h0000_0000);
    check("wr_in1", bus.out_inst, 32'h1000);

    // Irregular ready pattern with occasional redirects
    rdy_pat = 48'hB5_3C_E1_96_0F_7A;
    for (int i = 0; i < 48; i++) begin
      step();
      bus.out_ready = rdy_pat[i];
      bus.redirect_valid = (i % 17 == 9);
      bus.redirect_pc = 32'h200 + 32'(i * 36) + 32'(i % 4);
    end
    step();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Reset pulse between edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ar_addr", bus.imem_addr, RESET_PC);
    check("ar_out_pc", bus.out_pc, 32'd0);
    step();
    rst = 1'b0;
    startup_checks();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port imem_addr  output  32  byte address to the instruction memory, which returns the word one cycle later.
REQ-005 SHALL have port imem_inst  input  32  instruction word for the imem_addr presented in the previous cycle.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target.
REQ-008 SHALL have port out_valid  output  1  out_pc/out_inst hold a valid fetched instruction.
REQ-009 SHALL have port out_ready  input  1  decode accepts the output this cycle.
REQ-010 SHALL have port out_pc  output  32  address of out_inst.
REQ-011 SHALL have port out_inst  output  32  fetched instruction.

Function
REQ-012 SHALL hold the fetch PC in register pc_q and drive imem_addr = pc_q combinationally from that register.
REQ-013 SHALL contain a 2-entry FIFO of {pc, inst} entries feeding out_pc/out_inst from its head; out_valid = FIFO not empty.
REQ-014 SHALL track one in-flight request with flag inflight_q and its PC inflight_pc_q.
REQ-015 SHALL issue a request in cycle t iff redirect_valid=0 and (fifo_count + inflight_q - pop) < 2, where pop = out_valid & out_ready.
REQ-016 On issue, SHALL set inflight_q=1, set inflight_pc_q=pc_q, and set pc_q <= pc_q + 4 (modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000).
REQ-017 Without issue, SHALL hold pc_q, so imem_addr is stable.
REQ-018 When inflight_q=1 and redirect_valid=0, SHALL push {inflight_pc_q, imem_inst} into the FIFO at the clock edge.
REQ-019 SHALL perform push and pop in the same cycle with count unchanged; SHALL never overflow, guaranteed by REQ-015.
REQ-020 Latency: an address issued in cycle t SHALL appear with out_valid=1 in cycle t+2.
REQ-021 Throughput: with out_ready held high, SHALL deliver one instruction per cycle with no bubbles.
REQ-022 While out_valid=1 and out_ready=0, out_pc and out_inst SHALL remain stable.
REQ-023 On redirect_valid=1, SHALL flush the FIFO, clear inflight_q (the in-flight response is discarded), and set pc_q <= {redirect_pc[31:2], 2'b00}; no request is issued that cycle.
REQ-024 A handshake (out_valid & out_ready) in a redirect cycle SHALL count as completed; the entry SHALL be removed by the flush.
REQ-025 Redirect in consecutive cycles SHALL take the last target; the first post-redirect issue SHALL occur in the first cycle with redirect_valid=0.
REQ-026 SHALL contain no combinational path from imem_inst to any output.

Reset
REQ-027 While rst=1, asynchronously: pc_q=RESET_PC (imem_addr=RESET_PC), inflight_q=0, FIFO empty, out_valid=0, out_pc=0, out_inst=0.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered instructions; the first fetch after release SHALL be RESET_PC.

Verification
REQ-029 Reset release with out_ready=1 and a memory of word i = 0x1000+i -> imem_addr 0,4,8 in cycles 0,1,2; out_valid from cycle 2 with (out_pc, out_inst) = (0,0x1000), (4,0x1001), (8,0x1002) on consecutive cycles.
REQ-030 out_ready=0 for 5 cycles mid-stream -> out_pc/out_inst frozen; imem_addr frozen once 2 entries are buffered or in flight; after release, the sequence continues with no loss or duplication.
REQ-031 Redirect to 0x40 with the FIFO full -> next cycle out_valid=0 and imem_addr=0x40; out_pc=0x40 two cycles later; no pre-redirect PC appears afterwards.
REQ-032 Redirect to 0x43 -> fetch resumes at 0x40.
REQ-033 Redirect to 0xFFFF_FFFC -> outputs 0xFFFF_FFFC then 0x0000_0000.
REQ-034 rst pulse asserted between clock edges mid-stream -> out_valid=0 and imem_addr=RESET_PC immediately; after release, REQ-029 behaviour repeats.
